sparrow_fetch: RTL

- Instruction fetch stage, directly upstream of the decode stage.
- Owns the program counter and issues word-aligned requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned instruction words with their PC in a small in-order FIFO.
- Presents the words to decode over a valid/ready handshake; a redirect from execute flushes everything in flight.

---
 rtl/sparrow_pkg.sv | 12 +
 rtl/sparrow_fetch_fifo.sv | 60 ++++++
 rtl/sparrow_fetch.sv | 96 +++++++++
 3 files changed

// File: rtl/sparrow_pkg.sv
// Shared types and constants for the sparrow core front end.
package sparrow_pkg;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam int          FETCH_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sparrow_fetch_fifo.sv
// In-order instruction buffer between the memory response port and decode.
// Holds {pc, instr} entries; flush drops everything in one cycle.
module sparrow_fetch_fifo
    import sparrow_pkg::*;
#(
    parameter int DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  fetch_entry_t                 i_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output fetch_entry_t                 o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/sparrow_fetch.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction
// memory, buffers returned words with their PC and hands them to decode.
module sparrow_fetch
    import sparrow_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      r_pc;
    logic [31:0]      r_resp_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;

    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_inflight;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_data;
    logic             w_req;
    logic             w_grant;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_valid;
    logic [31:0]      w_redirect_pc;
    logic             w_unused;

    // Handshakes: a memory request transfers when o_imem_req & i_imem_gnt, a
    // response arrives on i_imem_rvalid (in order), and decode takes a word
    // when o_valid & i_ready. The address is held while req is up without gnt.
    assign w_inflight    = {1'b0, r_outstanding} + {1'b0, w_count};
    assign w_req         = !i_rst && !i_redirect && (w_inflight < (CNT_W+1)'(FIFO_DEPTH));
    assign w_grant       = w_req && i_imem_gnt;
    assign w_push        = i_imem_rvalid && !i_redirect && (r_discard == '0);
    assign w_fifo_valid  = !i_rst && (w_count != '0);
    assign w_pop         = w_fifo_valid && i_ready && !i_redirect;
    assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};
    assign w_push_data   = '{pc: r_resp_pc, instr: i_imem_rdata};
    assign w_unused      = ^i_redirect_pc[1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc          <= BOOT_ADDR;
            r_resp_pc     <= BOOT_ADDR;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(i_imem_rvalid);
            if (i_redirect) begin
                // Everything still in flight belongs to the old path.
                r_pc      <= w_redirect_pc;
                r_resp_pc <= w_redirect_pc;
                r_discard <= r_outstanding - CNT_W'(i_imem_rvalid);
            end else begin
                if (w_grant) r_pc <= r_pc + 32'd4;
                if (w_push)  r_resp_pc <= r_resp_pc + 32'd4;
                if (i_imem_rvalid && (r_discard != '0)) r_discard <= r_discard - 1'b1;
            end
        end
    end

    sparrow_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_redirect),
        .i_data  (w_push_data),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc;
    assign o_valid     = w_fifo_valid;
    assign o_instr     = w_fifo_valid ? w_head.instr : INSTR_NOP;
    assign o_pc        = w_fifo_valid ? w_head.pc : 32'h0000_0000;

endmodule
